seven_seg_scan_drv: RTL
=======================

# seven_seg_scan_drv

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It takes the 32-bit `disp_num` word produced by the GPIO 7-seg device stage and shows it as eight hex digits, one nibble per digit, scanning one digit at a time. The block adds per-digit decimal point, blanking and blink control. It snapshots its inputs once per frame so a digit pattern never tears mid-scan.

## Interface
Parameters:
- `DIV_BITS`, default 17: prescaler width; digit advances every 2^DIV_BITS clocks.
- `BLINK_BITS`, default 25: blink counter width; blink phase is its MSB.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `disp_num`  in  32  value to display; digit i shows `disp_num[4i+3:4i]`.
- `point`  in  8  decimal point enable per digit, active-high.
- `blank`  in  8  digit blank per digit, active-high.
- `blink_en`  in  8  blink enable per digit, active-high.
- `AN`  out  8  digit anodes, active-low, one-hot-low when lit.
- `SEGMENT`  out  8  `{dp,g,f,e,d,c,b,a}`, active-low.
- `frame_sync`  out  1  one-cycle pulse when a new frame snapshot is taken.

## Operation
- Prescaler `div_cnt` (DIV_BITS) increments every clock and wraps. `tick` is asserted when `div_cnt` is all ones.
- Digit index `idx` (3 bits) increments on `tick` and wraps from 7 to 0.
- Frame snapshot: on a `tick` with `idx==7`, the block does three things on the same edge.
  - Loads shadow registers `sh_num`, `sh_point`, `sh_blank` and `sh_blink` from the inputs.
  - Sets `idx` to 0.
  - Pulses `frame_sync`.
- Input changes at any other time have no effect until the next snapshot.
- Blink counter `blk_cnt` (BLINK_BITS) is free-running. `blink_off = blk_cnt[MSB]`.
- Digit i = `idx` is dark if `sh_blank[i]`, or if `sh_blink[i] & blink_off`.
  - Dark: `AN = 8'hFF`, `SEGMENT = 8'hFF`.
  - Lit: `AN = ~(8'b1 << i)`.
- `SEGMENT[6:0]` comes from a hex decode of nibble `sh_num[4i+3:4i]`, active-low, bit order gfedcba:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- `SEGMENT[7] = ~sh_point[i]`.
- Blank overrides point: a dark digit never lights dp.
- `AN`, `SEGMENT` and `frame_sync` are registered outputs. There is no combinational path from the inputs to the outputs.

## Timing
- Reset values:
  - `div_cnt = 0`, `idx = 7`, `blk_cnt = 0`.
  - `sh_num = 0`, `sh_point = 0`, `sh_blank = 8'hFF`, `sh_blink = 0`.
  - `AN = 8'hFF`, `SEGMENT = 8'hFF`, `frame_sync = 0`.
- The display stays dark until the first tick. That tick, 2^DIV_BITS cycles after reset release, is a snapshot tick because `idx` resets to 7.
- On every tick edge, `AN`/`SEGMENT` switch to the new `idx` using the new shadow values (on snapshot ticks). Outputs are constant between ticks, except for blink transitions.
- A blink transition toggles the current digit on the edge where `blk_cnt[MSB]` changes, with no extra latency.
- `frame_sync` is high for exactly the one cycle following the snapshot edge, i.e. coincident with digit 0 first being driven.
- Frame period = 8·2^DIV_BITS clocks. With 100 MHz and DIV_BITS=17, that is about 95 Hz.
- Asserting `rst` mid-scan immediately forces all registers to their reset values, with no clock needed. After release, the sequence restarts exactly as from power-up.
- Simultaneous events:
  - A snapshot tick and a blink toggle on the same edge: both take effect on that edge.
  - An input change on the snapshot edge: the value sampled on that edge is the one used.

## Test plan
- Reset/first frame (DIV_BITS=2, BLINK_BITS=6):
  - Apply `rst`, then drive `disp_num=32'h76543210` with `blank=0`.
  - Required: `AN=FF`, `SEGMENT=FF` for 4 cycles after release.
  - Then `frame_sync` pulses once, `AN=FE`, `SEGMENT=C0`.
  - Next ticks give `AN=FD/SEGMENT=F9`, `AN=FB/SEGMENT=A4`, and so on.
- Full hex sweep:
  - Drive `disp_num=32'hFEDCBA98` and then `32'h76543210`.
  - Required: all 16 decode values exactly as listed, on the correct anode.
  - Required: idx wraps 7→0 with `frame_sync` once per 32 cycles.
- Tear-free snapshot:
  - Change `disp_num` from `32'h11111111` to `32'h22222222` while `idx=3`.
  - Required: digits 4–7 still show `SEGMENT=F9`.
  - Required: `SEGMENT=A4` appears only from the next digit 0 onward.
- Point/blank:
  - Drive `point=8'h01` and `blank=8'h80`.
  - Required: digit 0 shows `SEGMENT[7]=0`.
  - Required: digit 7 gives `AN=FF`, `SEGMENT=FF` during its slot, even with `point[7]=1`.
- Blink:
  - Drive `blink_en=8'h04`.
  - Required: digit 2 is dark while `blk_cnt[5]=1` and lit while it is 0.
  - Required: other digits are unaffected.
- Async reset mid-scan:
  - Assert `rst` between clock edges at `idx=5`.
  - Required: `AN=FF`, `SEGMENT=FF` immediately, before any clock edge.
  - Required: the post-release sequence is identical to the first scenario.

Source files
------------

// File: rtl/seven_seg_scan_drv.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Inputs are snapshotted once per frame so a frame never mixes two values.
module seven_seg_scan_drv #(
  parameter int DIV_BITS   = 17,
  parameter int BLINK_BITS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_num,
  input  logic [7:0]  point,
  input  logic [7:0]  blank,
  input  logic [7:0]  blink_en,
  output logic [7:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        frame_sync
);

  localparam logic [DIV_BITS-1:0]   DIV_ONE = {{(DIV_BITS-1){1'b0}}, 1'b1};
  localparam logic [BLINK_BITS-1:0] BLK_ONE = {{(BLINK_BITS-1){1'b0}}, 1'b1};

  logic [DIV_BITS-1:0]   div_cnt_reg, div_cnt_next;
  logic [BLINK_BITS-1:0] blk_cnt_reg, blk_cnt_next;
  logic [2:0]            idx_reg, idx_next;
  logic [31:0]           sh_num_reg, sh_num_next;
  logic [7:0]            sh_point_reg, sh_point_next;
  logic [7:0]            sh_blank_reg, sh_blank_next;
  logic [7:0]            sh_blink_reg, sh_blink_next;
  logic [7:0]            an_reg, an_next;
  logic [7:0]            seg_reg, seg_next;
  logic                  frame_sync_reg, frame_sync_next;

  logic                  tick;
  logic                  snap;
  logic                  blink_off_next;
  logic                  dark_next;
  logic [3:0]            digit_nib [8];

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'h7F;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign tick = &div_cnt_reg;
  assign snap = tick && (idx_reg == 3'd7);

  // Nibbles come from the next-state shadow so a snapshot edge drives new data at once.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      assign digit_nib[gi] = sh_num_next[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    div_cnt_next    = div_cnt_reg + DIV_ONE;
    blk_cnt_next    = blk_cnt_reg + BLK_ONE;
    idx_next        = idx_reg;
    sh_num_next     = sh_num_reg;
    sh_point_next   = sh_point_reg;
    sh_blank_next   = sh_blank_reg;
    sh_blink_next   = sh_blink_reg;
    frame_sync_next = 1'b0;
    if (tick) begin
      idx_next = idx_reg + 3'd1;
    end
    if (snap) begin
      idx_next        = 3'd0;
      sh_num_next     = disp_num;
      sh_point_next   = point;
      sh_blank_next   = blank;
      sh_blink_next   = blink_en;
      frame_sync_next = 1'b1;
    end
  end

  // Output decode looks at next-state values so blink and digit changes land with no lag.
  always_comb begin
    blink_off_next = blk_cnt_next[BLINK_BITS-1];
    dark_next      = sh_blank_next[idx_next] | (sh_blink_next[idx_next] & blink_off_next);
    an_next        = 8'hFF;
    seg_next       = 8'hFF;
    if (!dark_next) begin
      an_next  = ~(8'b0000_0001 << idx_next);
      seg_next = {~sh_point_next[idx_next], hex_to_seg(digit_nib[idx_next])};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg    <= '0;
      blk_cnt_reg    <= '0;
      idx_reg        <= 3'd7;
      sh_num_reg     <= 32'h0;
      sh_point_reg   <= 8'h00;
      sh_blank_reg   <= 8'hFF;
      sh_blink_reg   <= 8'h00;
      an_reg         <= 8'hFF;
      seg_reg        <= 8'hFF;
      frame_sync_reg <= 1'b0;
    end else begin
      div_cnt_reg    <= div_cnt_next;
      blk_cnt_reg    <= blk_cnt_next;
      idx_reg        <= idx_next;
      sh_num_reg     <= sh_num_next;
      sh_point_reg   <= sh_point_next;
      sh_blank_reg   <= sh_blank_next;
      sh_blink_reg   <= sh_blink_next;
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      frame_sync_reg <= frame_sync_next;
    end
  end

  assign AN         = an_reg;
  assign SEGMENT    = seg_reg;
  assign frame_sync = frame_sync_reg;

endmodule
